channel_scheduler: RTL and testbench

CHANNEL_SCHEDULER -- requirements
Module: channel_scheduler

---
 rtl/channel_scheduler_pkg.sv | 27 ++
 rtl/channel_scheduler_rr_arbiter.sv | 51 +++++
 rtl/channel_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_channel_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// channel_scheduler_pkg
// Shared definitions for the channel scheduler: FSM state encoding, the header
// marker nibble, default channel count / length width (aligned with the
// NUM_SOURCES value used by the source channels) and an index-width helper.
// -----------------------------------------------------------------------------
package channel_scheduler_pkg;

  localparam int NUM_SOURCES = 8;
  localparam int DEF_LEN_W   = 8;

  localparam logic [3:0] HDR_NIBBLE = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_HEADER = 3'd2,
    ST_DATA   = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/channel_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational rotating-priority arbiter. The search starts at ptr_i
// and wraps modulo NUM_CH; the first requesting channel wins. Driving ptr_i
// with zero turns it into a fixed-priority (lowest index wins) arbiter.
//
// Ports
//   req_i  [NUM_CH]  request vector
//   ptr_i  [IDX_W]   first index to consider (must be < NUM_CH)
//   gnt_o  [NUM_CH]  one-hot grant, all zero when nothing requests
//   idx_o  [IDX_W]   index of the granted channel (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter
  import channel_scheduler_pkg::*;
#(
  parameter int NUM_CH = NUM_SOURCES
) (
  input  logic [NUM_CH-1:0]              req_i,
  input  logic [idx_width(NUM_CH)-1:0]   ptr_i,
  output logic [NUM_CH-1:0]              gnt_o,
  output logic [idx_width(NUM_CH)-1:0]   idx_o
);

  localparam int IDX_W = idx_width(NUM_CH);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    sum   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      // One extra bit keeps ptr + offset from overflowing before the wrap.
      sum = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_CH)) begin
        sum = sum - (IDX_W+1)'(NUM_CH);
      end
      cand = sum[IDX_W-1:0];
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/channel_scheduler.sv
// -----------------------------------------------------------------------------
// channel_scheduler
// Picks one source channel holding a complete message, optionally writes a
// header word, then streams the message words from the channel's show-ahead
// FIFO into the USB slave FIFO, honouring FLAG_FULL back-pressure. A short
// packet commit (PKTEND_REQ) follows every message that wrote anything.
//
// State table
//   state  | meaning
//   IDLE   | no transfer; arbitrate among GOT_FULL_MSG
//   GRANT  | channel chosen; latch its length into the word counter
//   HEADER | write {A, ch, len} header word (HEADER_EN only)
//   DATA   | pop + write one word per non-full cycle until counter hits 0
//   FINISH | pulse MSG_SENT / PKTEND_REQ, advance round-robin pointer
//
// Ports
//   CLK           in   system clock (ifclk)
//   RST           in   asynchronous active-low reset
//   GOT_FULL_MSG  in   [NUM_CH] channel holds a complete message
//   MSG_LEN_BUS   in   [NUM_CH*LEN_W] head-message word count per channel
//   FIFO_Q_BUS    in   [NUM_CH*DATA_W] show-ahead head word per channel
//   FLAG_FULL     in   USB endpoint full, no write this cycle
//   RD_REQ        out  [NUM_CH] pop one word from a channel FIFO
//   MSG_SENT      out  [NUM_CH] one-cycle pulse, message forwarded
//   WR_EN         out  write strobe toward the USB slave FIFO
//   WR_DATA       out  [DATA_W] write word (0 when WR_EN is low)
//   PKTEND_REQ    out  one-cycle short-packet commit
//   BUSY          out  FSM not in IDLE
//   CUR_CH        out  granted channel index
// -----------------------------------------------------------------------------
module channel_scheduler
  import channel_scheduler_pkg::*;
#(
  parameter int NUM_CH    = NUM_SOURCES,
  parameter int DATA_W    = 16,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int ARB_MODE  = 0,
  parameter int HEADER_EN = 1
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NUM_CH-1:0]               GOT_FULL_MSG,
  input  logic [NUM_CH*LEN_W-1:0]         MSG_LEN_BUS,
  input  logic [NUM_CH*DATA_W-1:0]        FIFO_Q_BUS,
  input  logic                            FLAG_FULL,
  output logic [NUM_CH-1:0]               RD_REQ,
  output logic [NUM_CH-1:0]               MSG_SENT,
  output logic                            WR_EN,
  output logic [DATA_W-1:0]               WR_DATA,
  output logic                            PKTEND_REQ,
  output logic                            BUSY,
  output logic [idx_width(NUM_CH)-1:0]    CUR_CH
);

  localparam int IDX_W = idx_width(NUM_CH);

  state_e              state_q;
  logic [IDX_W-1:0]    cur_ch_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [LEN_W-1:0]    len_q;
  logic                busy_q;
  logic [NUM_CH-1:0]   msg_sent_q;
  logic                pktend_q;

  logic [LEN_W-1:0]    len_arr [NUM_CH];
  logic [DATA_W-1:0]   q_arr   [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign len_arr[g] = MSG_LEN_BUS[LEN_W*g +: LEN_W];
    assign q_arr[g]   = FIFO_Q_BUS[DATA_W*g +: DATA_W];
  end

  logic [NUM_CH-1:0]   arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic [IDX_W-1:0]    arb_ptr;
  logic                arb_valid;

  // Fixed priority is the same search anchored at channel 0.
  assign arb_ptr   = (ARB_MODE == 1) ? '0 : ptr_q;
  assign arb_valid = |arb_gnt;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req_i (GOT_FULL_MSG),
    .ptr_i (arb_ptr),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  logic [LEN_W-1:0]    cur_len;
  logic [NUM_CH-1:0]   cur_onehot;
  logic [IDX_W-1:0]    next_ptr;
  logic [DATA_W-1:0]   hdr_word;

  assign cur_len    = len_arr[cur_ch_q];
  assign cur_onehot = NUM_CH'(1) << cur_ch_q;
  assign next_ptr   = (cur_ch_q == IDX_W'(NUM_CH-1)) ? '0 : cur_ch_q + 1'b1;

  // Marker and channel occupy the top byte; length fills the bits below it.
  always_comb begin
    hdr_word                = DATA_W'(len_q);
    hdr_word[DATA_W-1 -: 8] = {HDR_NIBBLE, 4'(cur_ch_q)};
  end

  // Write/pop strobes are combinational on FLAG_FULL so the FIFO pop and the
  // USB write land in the same cycle.
  always_comb begin
    WR_EN   = 1'b0;
    WR_DATA = '0;
    RD_REQ  = '0;
    case (state_q)
      ST_HEADER: begin
        if (!FLAG_FULL) begin
          WR_EN   = 1'b1;
          WR_DATA = hdr_word;
        end
      end
      ST_DATA: begin
        if (!FLAG_FULL) begin
          WR_EN            = 1'b1;
          WR_DATA          = q_arr[cur_ch_q];
          RD_REQ[cur_ch_q] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // MSG_SENT/PKTEND_REQ are loaded on the transition into FINISH so they are
  // high exactly during FINISH. Entering FINISH from HEADER or DATA always
  // coincides with a write, so that path alone requests PKTEND.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      cur_ch_q   <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      busy_q     <= 1'b0;
      msg_sent_q <= '0;
      pktend_q   <= 1'b0;
    end else begin
      msg_sent_q <= '0;
      pktend_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            cur_ch_q <= arb_idx;
            busy_q   <= 1'b1;
            state_q  <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          len_q <= cur_len;
          cnt_q <= cur_len;
          if (HEADER_EN != 0) begin
            state_q <= ST_HEADER;
          end else if (cur_len == '0) begin
            state_q    <= ST_FINISH;
            msg_sent_q <= cur_onehot;
          end else begin
            state_q <= ST_DATA;
          end
        end
        ST_HEADER: begin
          if (!FLAG_FULL) begin
            if (len_q == '0) begin
              state_q    <= ST_FINISH;
              msg_sent_q <= cur_onehot;
              pktend_q   <= 1'b1;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (!FLAG_FULL) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == LEN_W'(1)) begin
              state_q    <= ST_FINISH;
              msg_sent_q <= cur_onehot;
              pktend_q   <= 1'b1;
            end
          end
        end
        ST_FINISH: begin
          ptr_q   <= next_ptr;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign MSG_SENT   = msg_sent_q;
  assign PKTEND_REQ = pktend_q;
  assign BUSY       = busy_q;
  assign CUR_CH     = cur_ch_q;

endmodule

// File: tb/tb_channel_scheduler.sv
module tb_channel_scheduler;

  localparam int NCH = 8;
  localparam int DW  = 16;
  localparam int LW  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]    got_a, got_f, got_n;
  logic [NCH*LW-1:0] len_bus;
  logic [NCH*DW-1:0] q_bus;
  logic              full;
  logic [7:0]        pop [NCH];

  logic [NCH-1:0] rd_a, ms_a, rd_f, ms_f, rd_n, ms_n_o;
  logic           wr_a, pe_a, busy_a, wr_f, pe_f, busy_f, wr_n_o, pe_n_o, busy_n;
  logic [DW-1:0]  wd_a, wd_f, wd_n;
  logic [2:0]     cur_a, cur_f, cur_n;

  // Show-ahead FIFO model: word = {C, channel, pop count}.
  for (genvar g = 0; g < NCH; g++) begin : g_q
    assign q_bus[g*DW +: DW] = {4'hC, 4'(g), pop[g]};
  end

  channel_scheduler #(.NUM_CH(NCH), .DATA_W(DW), .LEN_W(LW), .ARB_MODE(0), .HEADER_EN(1)) u_dut (
    .CLK(clk), .RST(rst_n), .GOT_FULL_MSG(got_a), .MSG_LEN_BUS(len_bus), .FIFO_Q_BUS(q_bus),
    .FLAG_FULL(full), .RD_REQ(rd_a), .MSG_SENT(ms_a), .WR_EN(wr_a), .WR_DATA(wd_a),
    .PKTEND_REQ(pe_a), .BUSY(busy_a), .CUR_CH(cur_a));

  channel_scheduler #(.NUM_CH(NCH), .DATA_W(DW), .LEN_W(LW), .ARB_MODE(1), .HEADER_EN(1)) u_fp (
    .CLK(clk), .RST(rst_n), .GOT_FULL_MSG(got_f), .MSG_LEN_BUS(len_bus), .FIFO_Q_BUS(q_bus),
    .FLAG_FULL(1'b0), .RD_REQ(rd_f), .MSG_SENT(ms_f), .WR_EN(wr_f), .WR_DATA(wd_f),
    .PKTEND_REQ(pe_f), .BUSY(busy_f), .CUR_CH(cur_f));

  channel_scheduler #(.NUM_CH(NCH), .DATA_W(DW), .LEN_W(LW), .ARB_MODE(0), .HEADER_EN(0)) u_nh (
    .CLK(clk), .RST(rst_n), .GOT_FULL_MSG(got_n), .MSG_LEN_BUS(len_bus), .FIFO_Q_BUS(q_bus),
    .FLAG_FULL(1'b0), .RD_REQ(rd_n), .MSG_SENT(ms_n_o), .WR_EN(wr_n_o), .WR_DATA(wd_n),
    .PKTEND_REQ(pe_n_o), .BUSY(busy_n), .CUR_CH(cur_n));

  int          n_chk, n_fail;
  logic [15:0] wq [$];
  int          ga [$], gf [$];
  int          rd_cnt [NCH], ms_cnt [NCH], ms_n [NCH];
  int          pe_cnt, wr_n, pe_n;
  logic        busy_p_a, busy_p_f, auto_clr;
  logic [NCH-1:0] pend_pop, clr_a, clr_n;
  int          base;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] dword(input int c, input int k);
    return {4'hC, 4'(c), 8'(k)};
  endfunction

  task automatic set_len(input int c, input int l);
    len_bus[c*LW +: LW] = LW'(l);
  endtask

  task automatic clr_stats();
    wq.delete(); ga.delete(); gf.delete();
    for (int c = 0; c < NCH; c++) begin
      rd_cnt[c] = 0; ms_cnt[c] = 0; ms_n[c] = 0;
    end
    pe_cnt = 0; wr_n = 0; pe_n = 0;
  endtask

  task automatic sample();
    if (!wr_a) chk("wdata_zero", 32'(wd_a), 0);
    chk("rd_onehot0", 32'($onehot0(rd_a)), 1);
    if (rd_a != '0) chk("rd_with_wr", 32'(wr_a), 1);
    if (!busy_a) chk("idle_quiet", 32'({wr_a, rd_a, ms_a, pe_a}), 0);
    if (full) begin
      chk("stall_wr", 32'(wr_a), 0);
      chk("stall_rd", 32'(rd_a), 0);
    end
    if (wr_a) wq.push_back(wd_a);
    for (int c = 0; c < NCH; c++) begin
      if (rd_a[c]) begin rd_cnt[c]++; pend_pop[c] = 1'b1; end
      if (ms_a[c]) begin ms_cnt[c]++; if (auto_clr) clr_a[c] = 1'b1; end
      if (ms_n_o[c]) begin ms_n[c]++; clr_n[c] = 1'b1; end
    end
    if (pe_a) pe_cnt++;
    if (wr_n_o) wr_n++;
    if (pe_n_o) pe_n++;
    if (busy_a && !busy_p_a) ga.push_back(int'(cur_a));
    if (busy_f && !busy_p_f) gf.push_back(int'(cur_f));
    busy_p_a = busy_a;
    busy_p_f = busy_f;
  endtask

  // One clock: observe at the falling edge, update the FIFO model and drive
  // request drops just after the rising edge.
  task automatic tick();
    @(negedge clk);
    pend_pop = '0; clr_a = '0; clr_n = '0;
    sample();
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) if (pend_pop[c]) pop[c] = pop[c] + 8'd1;
    got_a = got_a & ~clr_a;
    got_n = got_n & ~clr_n;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    got_a = '0; got_f = '0; got_n = '0; len_bus = '0; full = 1'b0;
    for (int c = 0; c < NCH; c++) pop[c] = 8'd0;
    busy_p_a = 1'b0; busy_p_f = 1'b0; auto_clr = 1'b1;
    pend_pop = '0; clr_a = '0; clr_n = '0;
    clr_stats();

    // Reset state
    #3;
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_strobes", 32'({wr_a, rd_a, ms_a, pe_a}), 0);
    chk("rst_cur_ch", 32'(cur_a), 0);
    chk("rst_wdata", 32'(wd_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    settle(2);

    // Channel 2, length 3, with header
    clr_stats();
    base = int'(pop[2]);
    set_len(2, 3);
    got_a[2] = 1'b1;
    for (int i = 0; i < 100; i++) begin if (ms_cnt[2] != 0) break; tick(); end
    chk("t1_done", 32'(ms_cnt[2] != 0), 1);
    settle(4);
    chk("t1_nwr", 32'(wq.size()), 4);
    chk("t1_hdr", 32'(wq[0]), 32'h0000_A203);
    for (int k = 0; k < 3; k++) chk("t1_word", 32'(wq[k+1]), 32'(dword(2, base + k)));
    chk("t1_rd", 32'(rd_cnt[2]), 3);
    chk("t1_msg", 32'(ms_cnt[2]), 1);
    chk("t1_pkt", 32'(pe_cnt), 1);
    chk("t1_grant", 32'(ga[0]), 2);

    // Round-robin vs fixed priority with channels 0,3,5 requesting
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clr_stats();
    auto_clr = 1'b0;
    set_len(0, 1); set_len(3, 1); set_len(5, 1);
    got_a = 8'b0010_1001;
    got_f = 8'b0010_1001;
    for (int i = 0; i < 400; i++) begin
      if (ga.size() >= 4) got_a = '0;
      if (gf.size() >= 3) got_f = '0;
      if (ga.size() >= 4 && gf.size() >= 3) break;
      tick();
    end
    settle(20);
    auto_clr = 1'b1;
    chk("rr_count", 32'(ga.size() >= 4), 1);
    chk("rr_g0", 32'(ga[0]), 0);
    chk("rr_g1", 32'(ga[1]), 3);
    chk("rr_g2", 32'(ga[2]), 5);
    chk("rr_g3", 32'(ga[3]), 0);
    chk("fp_count", 32'(gf.size() >= 3), 1);
    for (int k = 0; k < 3; k++) chk("fp_grant", 32'(gf[k]), 0);

    // Back-pressure: 5 stall cycles at data word 2 of 4
    clr_stats();
    base = int'(pop[1]);
    set_len(1, 4);
    got_a[1] = 1'b1;
    for (int i = 0; i < 100; i++) begin if (wq.size() >= 2) break; tick(); end
    chk("t3_reach", 32'(wq.size()), 2);
    full = 1'b1;
    settle(5);
    full = 1'b0;
    for (int i = 0; i < 100; i++) begin if (ms_cnt[1] != 0) break; tick(); end
    settle(4);
    chk("t3_nwr", 32'(wq.size()), 5);
    chk("t3_hdr", 32'(wq[0]), 32'h0000_A104);
    for (int k = 0; k < 4; k++) chk("t3_word", 32'(wq[k+1]), 32'(dword(1, base + k)));
    chk("t3_rd", 32'(rd_cnt[1]), 4);
    chk("t3_msg", 32'(ms_cnt[1]), 1);
    chk("t3_pkt", 32'(pe_cnt), 1);

    // Zero-length messages, with and without header
    clr_stats();
    set_len(6, 0); set_len(4, 0);
    got_a[6] = 1'b1;
    got_n[4] = 1'b1;
    for (int i = 0; i < 100; i++) begin if (ms_cnt[6] != 0 && ms_n[4] != 0) break; tick(); end
    settle(4);
    chk("z_hdr_nwr", 32'(wq.size()), 1);
    chk("z_hdr_word", 32'(wq[0]), 32'h0000_A600);
    chk("z_hdr_pkt", 32'(pe_cnt), 1);
    chk("z_hdr_msg", 32'(ms_cnt[6]), 1);
    chk("z_hdr_rd", 32'(rd_cnt[6]), 0);
    chk("z_nh_wr", 32'(wr_n), 0);
    chk("z_nh_pkt", 32'(pe_n), 0);
    chk("z_nh_msg", 32'(ms_n[4]), 1);

    // Reset during data word 1 of 4; pointer must restart at 0
    clr_stats();
    base = int'(pop[3]);
    set_len(3, 4);
    got_a[3] = 1'b1;
    for (int i = 0; i < 100; i++) begin if (wq.size() >= 1) break; tick(); end
    chk("t5_reach", 32'(wq.size()), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy_a), 0);
    chk("t5_strobes", 32'({wr_a, rd_a, ms_a, pe_a}), 0);
    chk("t5_cur_ch", 32'(cur_a), 0);
    chk("t5_wdata", 32'(wd_a), 0);
    set_len(7, 2);
    got_a[7] = 1'b1;
    settle(2);
    chk("t5_no_msg", 32'(ms_cnt[3] + ms_cnt[7]), 0);
    chk("t5_no_pkt", 32'(pe_cnt), 0);
    chk("t5_no_pop", 32'(pop[3]), 32'(base));
    clr_stats();
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin if (ms_cnt[3] != 0 && ms_cnt[7] != 0) break; tick(); end
    settle(4);
    chk("t5_regrant", 32'(ga[0]), 3);
    chk("t5_next", 32'(ga[1]), 7);
    chk("t5_hdr", 32'(wq[0]), 32'h0000_A304);
    for (int k = 0; k < 4; k++) chk("t5_word", 32'(wq[k+1]), 32'(dword(3, base + k)));
    chk("t5_hdr7", 32'(wq[5]), 32'h0000_A702);
    chk("t5_pkt", 32'(pe_cnt), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
